// File: rtl/exc_handler.sv
`default_nettype none
// ============================================================================
// Module      : exc_handler
// Description : Exception sequencer: saves EPC, fetches the error vector and
//               loads it into the PC. EXC_CAUSE_REG_EN exposes the cause reg.
// Revision    : 1.0 - initial release
// ============================================================================
module exc_handler #(
  parameter int MEM_WAIT = 1,
  parameter int OPCODE_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       chk,
  input  logic       opcode_bad,
  input  logic       ovf,
  input  logic       div0,
  output logic       busy,
  output logic       epc_we,
  output logic       alu_epc,
  output logic [1:0] err_sel,
  output logic       iord_err,
  output logic       mdr_we,
  output logic       pc_we,
  output logic       done,
  output logic [1:0] cause
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SAVE_EPC = 3'd1,
    S_VEC_ADDR = 3'd2,
    S_WAIT     = 3'd3,
    S_LOAD_MDR = 3'd4,
    S_LOAD_PC  = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  localparam logic [2:0] c_WAIT_LOAD = 3'(MEM_WAIT);

  generate
    if (MEM_WAIT < 1 || MEM_WAIT > 7 || OPCODE_W < 1) begin : g_bad_cfg
      $error("exc_handler: MEM_WAIT must be 1..7 and OPCODE_W positive");
    end
  endgenerate

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_cnt;
  logic [1:0] r_cause;
  logic       w_fault;
  logic [1:0] w_cause_in;

  assign w_fault = opcode_bad | ovf | div0;

  // Fixed priority: opcode_bad > ovf > div0
  always_comb begin
    w_cause_in = 2'd0;
    if (opcode_bad)  w_cause_in = 2'd1;
    else if (ovf)    w_cause_in = 2'd2;
    else if (div0)   w_cause_in = 2'd3;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_cause <= 2'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (chk && w_fault) r_cause <= w_cause_in;
        end
        S_VEC_ADDR: r_cnt <= c_WAIT_LOAD;
        S_WAIT: begin
          if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
        end
`ifndef EXC_CAUSE_REG_EN
        // Without the visible cause register the value only lives for one sequence
        S_DONE: r_cause <= 2'd0;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next   = r_state;
    busy     = 1'b1;
    epc_we   = 1'b0;
    alu_epc  = 1'b0;
    err_sel  = 2'd0;
    iord_err = 1'b0;
    mdr_we   = 1'b0;
    pc_we    = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (chk && w_fault) w_next = S_SAVE_EPC;
      end
      S_SAVE_EPC: begin
        epc_we  = 1'b1;
        alu_epc = 1'b1;
        w_next  = S_VEC_ADDR;
      end
      S_VEC_ADDR: begin
        err_sel  = r_cause - 2'd1;
        iord_err = 1'b1;
        w_next   = S_WAIT;
      end
      S_WAIT: begin
        err_sel  = r_cause - 2'd1;
        iord_err = 1'b1;
        // Leave as the count hits zero so WAIT lasts exactly MEM_WAIT cycles
        if (r_cnt <= 3'd1) w_next = S_LOAD_MDR;
      end
      S_LOAD_MDR: begin
        err_sel  = r_cause - 2'd1;
        iord_err = 1'b1;
        mdr_we   = 1'b1;
        w_next   = S_LOAD_PC;
      end
      S_LOAD_PC: begin
        pc_we  = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

`ifdef EXC_CAUSE_REG_EN
  assign cause = r_cause;
`else
  assign cause = 2'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_exc_handler.sv
`default_nettype none
// ============================================================================
// Module      : tb_exc_handler
// Description : Vector-table bench for exc_handler (MEM_WAIT=1 and 3 copies).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exc_handler;

  logic       clk = 1'b0;
  logic       rst = 1'b0, chk = 1'b0, opcode_bad = 1'b0, ovf = 1'b0, div0 = 1'b0;
  logic       busy, epc_we, alu_epc, iord_err, mdr_we, pc_we, done;
  logic [1:0] err_sel, cause;
  logic       busy3, epc_we3, alu_epc3, iord_err3, mdr_we3, pc_we3, done3;
  logic [1:0] err_sel3, cause3;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  exc_handler #(.MEM_WAIT(1), .OPCODE_W(6)) dut (
    .clk(clk), .rst(rst), .chk(chk), .opcode_bad(opcode_bad), .ovf(ovf), .div0(div0),
    .busy(busy), .epc_we(epc_we), .alu_epc(alu_epc), .err_sel(err_sel),
    .iord_err(iord_err), .mdr_we(mdr_we), .pc_we(pc_we), .done(done), .cause(cause)
  );

  exc_handler #(.MEM_WAIT(3), .OPCODE_W(6)) dut3 (
    .clk(clk), .rst(rst), .chk(chk), .opcode_bad(opcode_bad), .ovf(ovf), .div0(div0),
    .busy(busy3), .epc_we(epc_we3), .alu_epc(alu_epc3), .err_sel(err_sel3),
    .iord_err(iord_err3), .mdr_we(mdr_we3), .pc_we(pc_we3), .done(done3), .cause(cause3)
  );

  // Input bits: {rst, chk, opcode_bad, ovf, div0}
  localparam logic [4:0] I_RST = 5'b00000;
  localparam logic [4:0] I_RUN = 5'b10000;
  localparam logic [4:0] I_CHK = 5'b11000;
  localparam logic [4:0] I_OB  = 5'b00100;
  localparam logic [4:0] I_OVF = 5'b00010;
  localparam logic [4:0] I_D0  = 5'b00001;

  typedef struct {
    logic [4:0]  in;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [1:0] exp_cause(input logic [1:0] c);
`ifdef EXC_CAUSE_REG_EN
    return c;
`else
    return 2'd0;
`endif
  endfunction

  // Expected {busy,epc_we,alu_epc,err_sel,iord_err,mdr_we,pc_we,done,cause}
  // for a handler state: 0 IDLE,1 SAVE_EPC,2 VEC_ADDR,3 WAIT,4 LOAD_MDR,5 LOAD_PC,6 DONE
  function automatic logic [10:0] ex(input int s, input logic [1:0] e, input logic [1:0] c);
    logic [1:0] cc;
    cc = exp_cause(c);
    case (s)
      1:       return {1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, cc};
      2, 3:    return {1'b1, 1'b0, 1'b0, e,    1'b1, 1'b0, 1'b0, 1'b0, cc};
      4:       return {1'b1, 1'b0, 1'b0, e,    1'b1, 1'b1, 1'b0, 1'b0, cc};
      5:       return {1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, cc};
      6:       return {1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, cc};
      default: return {1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, cc};
    endcase
  endfunction

  task automatic add(input logic [4:0] in, input logic [10:0] e);
    vec_t v;
    v.in  = in;
    v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic compare(input string name, input int got, input int req);
    n_vec++;
    if (got != req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  logic [10:0] got;
  int busy_n, done_n, errbad_n, span_n;
  int busy3_n, done3_n, errbad3_n, span3_n;

  initial begin
    // Full ovf sequence, MEM_WAIT=1
    add(I_RST, ex(0, 2'd0, 2'd0));
    add(I_CHK | I_OVF, ex(1, 2'd0, 2'd2));
    add(I_RUN, ex(2, 2'd1, 2'd2));
    add(I_RUN, ex(3, 2'd1, 2'd2));
    add(I_RUN, ex(4, 2'd1, 2'd2));
    add(I_RUN, ex(5, 2'd0, 2'd2));
    add(I_RUN, ex(6, 2'd0, 2'd2));
    add(I_RUN, ex(0, 2'd0, 2'd2));
    // All flags at once: opcode_bad wins
    add(I_CHK | I_OB | I_OVF | I_D0, ex(1, 2'd0, 2'd1));
    add(I_RUN, ex(2, 2'd0, 2'd1));
    add(I_RUN, ex(3, 2'd0, 2'd1));
    add(I_RUN, ex(4, 2'd0, 2'd1));
    add(I_RUN, ex(5, 2'd0, 2'd1));
    add(I_RUN, ex(6, 2'd0, 2'd1));
    add(I_RUN, ex(0, 2'd0, 2'd1));
    // Flags without chk, chk without flags: no sequence, cause held
    add(I_RUN | I_OVF, ex(0, 2'd0, 2'd1));
    add(I_CHK, ex(0, 2'd0, 2'd1));
    add(I_RUN | I_OB | I_D0, ex(0, 2'd0, 2'd1));
    // ovf beats div0
    add(I_CHK | I_OVF | I_D0, ex(1, 2'd0, 2'd2));
    add(I_RUN, ex(2, 2'd1, 2'd2));
    add(I_RUN, ex(3, 2'd1, 2'd2));
    add(I_RUN, ex(4, 2'd1, 2'd2));
    add(I_RUN, ex(5, 2'd0, 2'd2));
    add(I_RUN, ex(6, 2'd0, 2'd2));
    add(I_RUN, ex(0, 2'd0, 2'd2));
    // div0, new faults inside the sequence ignored, reset while in WAIT
    add(I_CHK | I_D0, ex(1, 2'd0, 2'd3));
    add(I_CHK | I_OVF, ex(2, 2'd2, 2'd3));
    add(I_CHK | I_OB, ex(3, 2'd2, 2'd3));
    add(I_RST | 5'b01010, ex(0, 2'd0, 2'd0));
    add(I_RUN, ex(0, 2'd0, 2'd0));
    // Complete sequence after the abort
    add(I_CHK | I_OVF, ex(1, 2'd0, 2'd2));
    add(I_RUN, ex(2, 2'd1, 2'd2));
    add(I_RUN, ex(3, 2'd1, 2'd2));
    add(I_RUN, ex(4, 2'd1, 2'd2));
    add(I_RUN, ex(5, 2'd0, 2'd2));
    add(I_RUN, ex(6, 2'd0, 2'd2));
    add(I_RUN, ex(0, 2'd0, 2'd2));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      {rst, chk, opcode_bad, ovf, div0} = vecs[i].in;
      @(posedge clk);
      #1;
      got = {busy, epc_we, alu_epc, err_sel, iord_err, mdr_we, pc_we, done, cause};
      n_vec++;
      if (got !== vecs[i].exp) begin
        n_bad++;
        $display("FAIL vec%0d: got %b required %b", i, got, vecs[i].exp);
      end
    end

    // Let the MEM_WAIT=3 copy drain before the parallel sequence
    repeat (6) begin
      @(negedge clk);
      {rst, chk, opcode_bad, ovf, div0} = I_RUN;
    end

    // div0 on both copies, second chk+ovf pulse while both sit in WAIT
    busy_n = 0; done_n = 0; errbad_n = 0; span_n = 0;
    busy3_n = 0; done3_n = 0; errbad3_n = 0; span3_n = 0;
    @(negedge clk);
    {rst, chk, opcode_bad, ovf, div0} = I_CHK | I_D0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      busy_n  += int'(busy);
      done_n  += int'(done);
      busy3_n += int'(busy3);
      done3_n += int'(done3);
      if (iord_err && err_sel != 2'd2) errbad_n++;
      if (iord_err3 && err_sel3 != 2'd2) errbad3_n++;
      if (iord_err && !mdr_we) span_n++;
      if (iord_err3 && !mdr_we3) span3_n++;
      @(negedge clk);
      {rst, chk, opcode_bad, ovf, div0} = (k == 2) ? (I_CHK | I_OVF) : I_RUN;
    end
    compare("mw1_busy_cycles", busy_n, 6);
    compare("mw1_done_pulses", done_n, 1);
    compare("mw1_err_sel_not2", errbad_n, 0);
    compare("mw1_vec_plus_wait", span_n, 2);
    compare("mw1_cause", int'(cause), int'(exp_cause(2'd3)));
    compare("mw3_busy_cycles", busy3_n, 8);
    compare("mw3_done_pulses", done3_n, 1);
    compare("mw3_err_sel_not2", errbad3_n, 0);
    compare("mw3_vec_plus_wait", span3_n, 4);
    compare("mw3_cause", int'(cause3), int'(exp_cause(2'd3)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
